// File: rtl/draw_sequencer.sv
// Draw sequencer: turns Key_0 press pulses into draw index Z, hold flag t and a
// seconds-remaining countdown; parks in DONE after the last draw until restart.
module draw_sequencer #(
  parameter int unsigned SEC_CYCLES = 50_000_000,
  parameter int unsigned HOLD_SECS  = 4,
  parameter int unsigned MAX_DRAWS  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_press,
  input  logic       restart,
  output logic [3:0] Z,
  output logic       t,
  output logic [3:0] secs_left,
  output logic       done
);

  localparam int unsigned CW = (SEC_CYCLES > 1) ? $clog2(SEC_CYCLES) : 1;
  localparam logic [CW-1:0] SEC_LAST  = CW'(SEC_CYCLES - 1);
  localparam logic [3:0]    HOLD_INIT = 4'(HOLD_SECS);
  localparam logic [3:0]    DRAW_LAST = 4'(MAX_DRAWS - 1);
  localparam logic [3:0]    DRAW_MAX  = 4'(MAX_DRAWS);

  typedef enum logic [1:0] {
    ROLL,
    HOLD,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   sec_cnt_q, sec_cnt_d;
  logic [3:0]      secs_q, secs_d;
  logic [3:0]      z_q, z_d;
  logic            t_q, t_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ROLL;
      sec_cnt_q <= '0;
      secs_q    <= '0;
      z_q       <= '0;
      t_q       <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sec_cnt_q <= sec_cnt_d;
      secs_q    <= secs_d;
      z_q       <= z_d;
      t_q       <= t_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sec_cnt_d = sec_cnt_q;
    secs_d    = secs_q;
    z_d       = z_q;
    t_d       = t_q;
    done_d    = done_q;

    // restart outranks both a press and a hold expiry landing on the same edge
    if (restart) begin
      state_d   = ROLL;
      sec_cnt_d = '0;
      secs_d    = '0;
      z_d       = '0;
      t_d       = 1'b0;
      done_d    = 1'b0;
    end else begin
      unique case (state_q)
        ROLL: begin
          if (key_press) begin
            state_d   = HOLD;
            t_d       = 1'b1;
            secs_d    = HOLD_INIT;
            sec_cnt_d = '0;
          end
        end
        HOLD: begin
          if (sec_cnt_q == SEC_LAST) begin
            sec_cnt_d = '0;
            if (secs_q > 4'd1) begin
              secs_d = secs_q - 4'd1;
            end else begin
              secs_d = '0;
              if (z_q < DRAW_LAST) begin
                z_d     = z_q + 4'd1;
                t_d     = 1'b0;
                state_d = ROLL;
              end else begin
                z_d     = DRAW_MAX;
                done_d  = 1'b1;
                state_d = DONE;
              end
            end
          end else begin
            sec_cnt_d = sec_cnt_q + CW'(1);
          end
        end
        DONE: begin
        end
        default: state_d = ROLL;
      endcase
    end
  end

  assign Z         = z_q;
  assign t         = t_q;
  assign secs_left = secs_q;
  assign done      = done_q;

endmodule

// File: tb/tb_draw_sequencer.sv
// Self-checking bench for draw_sequencer: constant vector table, directed corner
// sequences and a random run against a remaining-hold-cycles reference model.
module tb_draw_sequencer;

  localparam int SC  = 4, HS  = 2, MD  = 4;
  localparam int SC2 = 2, HS2 = 1, MD2 = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       kp = 1'b0, rs = 1'b0, kp2 = 1'b0, rs2 = 1'b0;
  logic [3:0] z, secs, z2, secs2;
  logic       t, done, t2, done2;

  always #5 clk = ~clk;

  draw_sequencer #(.SEC_CYCLES(SC), .HOLD_SECS(HS), .MAX_DRAWS(MD)) dut (
    .clk(clk), .rst(rst), .key_press(kp), .restart(rs),
    .Z(z), .t(t), .secs_left(secs), .done(done)
  );

  draw_sequencer #(.SEC_CYCLES(SC2), .HOLD_SECS(HS2), .MAX_DRAWS(MD2)) dut_min (
    .clk(clk), .rst(rst), .key_press(kp2), .restart(rs2),
    .Z(z2), .t(t2), .secs_left(secs2), .done(done2)
  );

  // Model state: cycles of hold still to run, draws completed, done flag.
  typedef struct {
    int rem;
    int zi;
    bit dn;
  } mstate_t;

  typedef struct {
    bit         kp;
    bit         rs;
    logic [9:0] exp;  // {Z, t, secs_left, done}
  } vec_t;

  mstate_t m1, m2;
  int      n_vec = 0;
  int      n_err = 0;
  vec_t    tbl[12];

  function automatic mstate_t mstep(mstate_t s, bit k, bit r, int sec, int hold, int maxd);
    mstate_t n = s;
    if (r) begin
      n.rem = 0; n.zi = 0; n.dn = 0;
    end else if (s.dn) begin
    end else if (s.rem > 0) begin
      n.rem = s.rem - 1;
      if (n.rem == 0) begin
        if (s.zi < maxd - 1) n.zi = s.zi + 1;
        else begin n.zi = maxd; n.dn = 1; end
      end
    end else if (k) begin
      n.rem = hold * sec;
    end
    return n;
  endfunction

  function automatic logic [9:0] mout(mstate_t s, int sec);
    int sl = (s.rem > 0) ? (s.rem + sec - 1) / sec : 0;
    return {4'(s.zi), 1'((s.rem > 0) || s.dn), 4'(sl), 1'(s.dn)};
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got Z=%0d t=%0b secs=%0d done=%0b, want Z=%0d t=%0b secs=%0d done=%0b",
               name, got[9:6], got[5], got[4:1], got[0], want[9:6], want[5], want[4:1], want[0]);
    end
  endtask

  task automatic tick(input bit a_kp, input bit a_rs, input bit b_kp, input bit b_rs);
    kp = a_kp; rs = a_rs; kp2 = b_kp; rs2 = b_rs;
    @(posedge clk);
    m1 = mstep(m1, a_kp, a_rs, SC, HS, MD);
    m2 = mstep(m2, b_kp, b_rs, SC2, HS2, MD2);
    #1;
    kp = 1'b0; rs = 1'b0; kp2 = 1'b0; rs2 = 1'b0;
    check("model_main", {z, t, secs, done}, mout(m1, SC));
    check("model_min", {z2, t2, secs2, done2}, mout(m2, SC2));
  endtask

  initial begin
    // Single draw with an ignored press on the edge where secs_left drops to 1.
    tbl[0]  = '{kp: 1'b0, rs: 1'b0, exp: {4'd0, 1'b0, 4'd0, 1'b0}};
    tbl[1]  = '{kp: 1'b1, rs: 1'b0, exp: {4'd0, 1'b1, 4'd2, 1'b0}};
    tbl[2]  = '{kp: 1'b0, rs: 1'b0, exp: {4'd0, 1'b1, 4'd2, 1'b0}};
    tbl[3]  = '{kp: 1'b0, rs: 1'b0, exp: {4'd0, 1'b1, 4'd2, 1'b0}};
    tbl[4]  = '{kp: 1'b0, rs: 1'b0, exp: {4'd0, 1'b1, 4'd2, 1'b0}};
    tbl[5]  = '{kp: 1'b1, rs: 1'b0, exp: {4'd0, 1'b1, 4'd1, 1'b0}};
    tbl[6]  = '{kp: 1'b0, rs: 1'b0, exp: {4'd0, 1'b1, 4'd1, 1'b0}};
    tbl[7]  = '{kp: 1'b0, rs: 1'b0, exp: {4'd0, 1'b1, 4'd1, 1'b0}};
    tbl[8]  = '{kp: 1'b0, rs: 1'b0, exp: {4'd0, 1'b1, 4'd1, 1'b0}};
    tbl[9]  = '{kp: 1'b0, rs: 1'b0, exp: {4'd1, 1'b0, 4'd0, 1'b0}};
    tbl[10] = '{kp: 1'b0, rs: 1'b0, exp: {4'd1, 1'b0, 4'd0, 1'b0}};
    tbl[11] = '{kp: 1'b0, rs: 1'b0, exp: {4'd1, 1'b0, 4'd0, 1'b0}};

    m1 = '{rem: 0, zi: 0, dn: 0};
    m2 = '{rem: 0, zi: 0, dn: 0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_main", {z, t, secs, done}, 10'd0);
    check("reset_min", {z2, t2, secs2, done2}, 10'd0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].kp, tbl[i].rs, 1'b0, 1'b0);
      check($sformatf("table[%0d]", i), {z, t, secs, done}, tbl[i].exp);
    end

    // Rest of the round: Z 1 -> 2 -> 3 -> 4 with DONE after the fourth hold.
    for (int d = 1; d <= 3; d++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (8) tick(1'b0, 1'b0, 1'b0, 1'b0);
      check($sformatf("round_draw%0d", d + 1), {z, t, secs, done},
            {4'(d + 1), 1'(d == 3), 4'd0, 1'(d == 3)});
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b0);
      check("done_ignores_press", {z, t, secs, done}, {4'd4, 1'b1, 4'd0, 1'b1});
    end

    tick(1'b1, 1'b1, 1'b0, 1'b0);
    check("restart_with_press_in_done", {z, t, secs, done}, 10'd0);

    // Restart on the exact hold-expiry edge.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (7) tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_expiry_hold", {z, t, secs, done}, {4'd0, 1'b1, 4'd1, 1'b0});
    tick(1'b0, 1'b1, 1'b0, 1'b0);
    check("restart_at_expiry", {z, t, secs, done}, 10'd0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("restart_at_expiry_next", {z, t, secs, done}, 10'd0);

    // Asynchronous reset in the middle of a hold, between clock edges.
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_midcycle", {z, t, secs, done}, 10'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m1 = '{rem: 0, zi: 0, dn: 0};
    m2 = '{rem: 0, zi: 0, dn: 0};
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("after_reset_roll", {z, t, secs, done}, 10'd0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    check("after_reset_press", {z, t, secs, done}, {4'd0, 1'b1, 4'd2, 1'b0});
    tick(1'b0, 1'b1, 1'b0, 1'b0);

    // Minimum-parameter instance: 2-cycle hold then DONE.
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("min_hold_c1", {z2, t2, secs2, done2}, {4'd0, 1'b1, 4'd1, 1'b0});
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("min_hold_c2", {z2, t2, secs2, done2}, {4'd0, 1'b1, 4'd1, 1'b0});
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    check("min_done", {z2, t2, secs2, done2}, {4'd1, 1'b1, 4'd0, 1'b1});
    tick(1'b0, 1'b0, 1'b1, 1'b0);
    check("min_done_ignores_press", {z2, t2, secs2, done2}, {4'd1, 1'b1, 4'd0, 1'b1});
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("min_restart", {z2, t2, secs2, done2}, 10'd0);

    // Random presses and restarts on both instances against the model.
    for (int i = 0; i < 800; i++) begin
      tick(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 59) == 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 19) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Sequencing controller for the four-draw random number display. Turns debounced Key_0 press pulses into the draw index `Z` and the hold flag `t` that drive the duplicate-avoiding number register. Each press freezes the current number for a fixed hold time and exposes a seconds-remaining countdown for the display. After the last draw it parks in a done state until restarted.

## Interface
- `SEC_CYCLES`, default 50_000_000: clock cycles per second of hold time; legal range ≥ 2.
- `HOLD_SECS`, default 4: hold duration in seconds; legal range 1..15.
- `MAX_DRAWS`, default 4: number of draws per round; legal range 1..15.
- `clk` in 1: system clock, single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `key_press` in 1: one-cycle pulse per debounced Key_0 press.
- `restart` in 1: one-cycle pulse that starts a new round.
- `Z` out 4: current draw index, 0..MAX_DRAWS.
- `t` out 1: hold flag; 1 means the displayed number is frozen.
- `secs_left` out 4: whole seconds of hold remaining, HOLD_SECS..1 during hold, 0 otherwise.
- `done` out 1: high once all draws are complete.

## Operation
- States:
  - ROLL: t=0, number rolling.
  - HOLD: t=1, counting.
  - DONE: t=1, done=1.
- Internal registers:
  - `sec_cnt`: counts 0..SEC_CYCLES-1, wide enough for SEC_CYCLES-1.
  - `secs_left`: seconds remaining.
- All outputs are registered.
- Reset (async, any time, including mid-hold): state=ROLL, Z=0, t=0, secs_left=0, done=0, sec_cnt=0.
- ROLL + key_press:
  - Go to HOLD; t=1, secs_left=HOLD_SECS, sec_cnt=0.
  - Z unchanged.
- HOLD, each cycle:
  - If sec_cnt=SEC_CYCLES-1 and secs_left>1: sec_cnt=0, secs_left decrements.
  - Otherwise sec_cnt increments.
- HOLD expiry (sec_cnt=SEC_CYCLES-1 and secs_left=1), on the next cycle:
  - secs_left=0 and sec_cnt=0.
  - If Z<MAX_DRAWS-1: Z increments, t=0, state=ROLL.
  - Else: Z=MAX_DRAWS, state=DONE, t stays 1, done=1.
- key_press during HOLD or DONE is ignored. It is not queued.
- restart in any state has priority over key_press and over hold expiry in the same cycle:
  - Next cycle: state=ROLL, Z=0, t=0, secs_left=0, sec_cnt=0, done=0.
- Z never exceeds MAX_DRAWS and never wraps.

## Timing
- key_press sampled high at edge n in ROLL: t=1 and secs_left=HOLD_SECS are visible after edge n.
  - The number register still sees t=0 at edge n, so it captures the current random value on that edge.
- t stays high for exactly HOLD_SECS×SEC_CYCLES cycles, then falls.
  - Z increments on the same edge that t falls.
- secs_left decrements every SEC_CYCLES cycles. Sequence: HOLD_SECS, …, 1, then 0 at expiry.
- restart takes effect one cycle after it is sampled.
- key_press takes effect one cycle after it is sampled.
- Rolling resumes one cycle after hold expiry.
- No combinational path from any input to any output.

## Test plan
Bench parameters: SEC_CYCLES=4, HOLD_SECS=2, MAX_DRAWS=4 (hold = 8 cycles).

- **Reset:** assert rst asynchronously mid-cycle during HOLD -> Z=0, t=0, secs_left=0, done=0 immediately, without waiting for a clock edge. After release, ROLL.
- **Single draw:** key_press at cycle 10 ->
  - t=1 at cycles 11–18.
  - secs_left=2 at cycles 11–14, 1 at cycles 15–18, 0 at cycle 19.
  - At cycle 19: t=0, Z=1.
- **Full round:** four presses, each issued after the previous hold has expired ->
  - Z steps 0→1→2→3.
  - After the fourth hold: Z=4, t=1, done=1.
  - A further key_press has no effect.
- **Ignored press:** key_press at cycle 14 during the hold started at cycle 10 -> timing identical to the single-draw case; no extra hold afterwards.
- **Restart collision:**
  - restart coincident with hold expiry -> next cycle Z=0, t=0, secs_left=0; Z does not pass through 1.
  - restart and key_press together in DONE -> ROLL with Z=0, t=0, done=0.
- **Minimum parameters:** SEC_CYCLES=2, HOLD_SECS=1, MAX_DRAWS=1 -> a single press gives t=1 for exactly 2 cycles, then DONE with Z=1, done=1.
